// File: rtl/parking_pkg.sv
// Shared definitions for the car-park barrier arbiter: FSM state encoding,
// lane identifiers and the active-low 7-segment glyph table used by the
// optional free-space display.
package parking_pkg;

    // Gate sequencing states
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_AUTH = 2'd1,
        ST_OPEN      = 2'd2,
        ST_CLOSE     = 2'd3
    } state_t;

    // Which lane currently owns (or last owned) the barrier
    typedef enum logic {
        LANE_ENTRY = 1'b0,
        LANE_EXIT  = 1'b1
    } lane_t;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;

    // Hex digit to active-low segment pattern
    function automatic logic [6:0] seg7Lookup(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'h0:    seg = SEG_0;
            4'h1:    seg = SEG_1;
            4'h2:    seg = SEG_2;
            4'h3:    seg = SEG_3;
            4'h4:    seg = SEG_4;
            4'h5:    seg = SEG_5;
            4'h6:    seg = SEG_6;
            4'h7:    seg = SEG_7;
            4'h8:    seg = SEG_8;
            4'h9:    seg = SEG_9;
            4'hA:    seg = SEG_A;
            4'hB:    seg = SEG_B;
            4'hC:    seg = SEG_C;
            4'hD:    seg = SEG_D;
            4'hE:    seg = SEG_E;
            default: seg = SEG_F;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational hex digit to active-low 7-segment decoder.
// Only instantiated when the free-space display (OCCUPANCY_DISPLAY_EN) is built.
module seg7_decoder
    import parking_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [6:0] o_seg
);

    assign o_seg = seg7Lookup(i_digit);

endmodule

// File: rtl/parking_gate_arbiter.sv
// Barrier gate arbiter for the car park: shares one gate between the entry
// and exit lanes, waits for password authorisation on entry, sequences the
// open/close cycle and tracks occupancy against CAPACITY.
// Optional feature: define OCCUPANCY_DISPLAY_EN to add the hex_free output,
// an active-low 7-segment display of the number of free spaces.
module parking_gate_arbiter
    import parking_pkg::*;
#(
    parameter int CAPACITY    = 8,
    parameter int CW          = 4,
    parameter int TIMEOUT_CYC = 64,
    parameter int CLOSE_CYC   = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_entry,
    input  logic          req_exit,
    input  logic          auth_ok,
    input  logic          gate_clear,
    output logic          grant_entry,
    output logic          grant_exit,
    output logic          gate_open,
    output logic          full,
    output logic [CW-1:0] occupancy,
    output logic          timeout_err
`ifdef OCCUPANCY_DISPLAY_EN
    ,
    output logic [6:0]    hex_free
`endif
);

    // The timer must be able to reach the larger of the two terminal counts
    localparam int TMAX = (TIMEOUT_CYC > CLOSE_CYC) ? TIMEOUT_CYC : CLOSE_CYC;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] CLOSE_LAST   = TW'(CLOSE_CYC - 1);
    localparam logic [CW-1:0] CAP_VAL      = CW'(CAPACITY);

    state_t        r_state;
    lane_t         r_lane;
    logic          r_prioEntry;
    logic [TW-1:0] r_timer;
    logic [CW-1:0] r_occupancy;
    logic          r_full;
    logic          r_grantEntry;
    logic          r_grantExit;
    logic          r_gateOpen;
    logic          r_timeoutErr;

    state_t        w_nextState;
    lane_t         w_nextLane;
    logic          w_nextPrio;
    logic [CW-1:0] w_occNext;
    logic          w_fullNext;
    logic          w_timeoutPulse;
    logic          w_eligEntry;
    logic          w_eligExit;
    logic          w_grantEntryNext;
    logic          w_grantExitNext;
    logic          w_gateOpenNext;

    // Next-state, arbitration, occupancy update and next registered outputs
    always_comb begin
        w_nextState    = r_state;
        w_nextLane     = r_lane;
        w_nextPrio     = r_prioEntry;
        w_occNext      = r_occupancy;
        w_timeoutPulse = 1'b0;
        w_eligEntry    = req_entry & ~r_full;
        w_eligExit     = req_exit & (r_occupancy != '0);

        case (r_state)
            ST_IDLE: begin
                if (w_eligEntry && w_eligExit) begin
                    if (r_prioEntry) begin
                        w_nextLane  = LANE_ENTRY;
                        w_nextState = ST_WAIT_AUTH;
                    end else begin
                        w_nextLane  = LANE_EXIT;
                        w_nextState = ST_OPEN;
                    end
                    w_nextPrio = ~r_prioEntry;
                end else if (w_eligEntry) begin
                    w_nextLane  = LANE_ENTRY;
                    w_nextState = ST_WAIT_AUTH;
                end else if (w_eligExit) begin
                    w_nextLane  = LANE_EXIT;
                    w_nextState = ST_OPEN;
                end
            end
            ST_WAIT_AUTH: begin
                if (auth_ok) begin
                    w_nextState = ST_OPEN;
                end else if (r_timer == TIMEOUT_LAST) begin
                    w_nextState    = ST_IDLE;
                    w_timeoutPulse = 1'b1;
                end
            end
            ST_OPEN: begin
                if (gate_clear) begin
                    w_nextState = ST_CLOSE;
                    if (r_lane == LANE_ENTRY) begin
                        if (r_occupancy != CAP_VAL) begin
                            w_occNext = r_occupancy + CW'(1);
                        end
                    end else begin
                        if (r_occupancy != '0) begin
                            w_occNext = r_occupancy - CW'(1);
                        end
                    end
                end else if (r_timer == TIMEOUT_LAST) begin
                    w_nextState    = ST_CLOSE;
                    w_timeoutPulse = 1'b1;
                end
            end
            ST_CLOSE: begin
                if (r_timer == CLOSE_LAST) begin
                    w_nextState = ST_IDLE;
                end
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase

        w_fullNext       = (w_occNext == CAP_VAL);
        w_grantEntryNext = (w_nextState != ST_IDLE) && (w_nextLane == LANE_ENTRY);
        w_grantExitNext  = (w_nextState != ST_IDLE) && (w_nextLane == LANE_EXIT);
        w_gateOpenNext   = (w_nextState == ST_OPEN);
    end

    // State, owning lane and round-robin priority registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_lane      <= LANE_ENTRY;
            r_prioEntry <= 1'b1;
        end else begin
            r_state     <= w_nextState;
            r_lane      <= w_nextLane;
            r_prioEntry <= w_nextPrio;
        end
    end

    // Per-state cycle timer, cleared on every state change and saturating
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_timer <= '0;
        end else if (w_nextState != r_state) begin
            r_timer <= '0;
        end else if (r_timer != '1) begin
            r_timer <= r_timer + TW'(1);
        end
    end

    // Occupancy counter and full flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_occupancy <= '0;
            r_full      <= 1'b0;
        end else begin
            r_occupancy <= w_occNext;
            r_full      <= w_fullNext;
        end
    end

    // Registered gate and status outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_grantEntry <= 1'b0;
            r_grantExit  <= 1'b0;
            r_gateOpen   <= 1'b0;
            r_timeoutErr <= 1'b0;
        end else begin
            r_grantEntry <= w_grantEntryNext;
            r_grantExit  <= w_grantExitNext;
            r_gateOpen   <= w_gateOpenNext;
            r_timeoutErr <= w_timeoutPulse;
        end
    end

    assign grant_entry = r_grantEntry;
    assign grant_exit  = r_grantExit;
    assign gate_open   = r_gateOpen;
    assign full        = r_full;
    assign occupancy   = r_occupancy;
    assign timeout_err = r_timeoutErr;

`ifdef OCCUPANCY_DISPLAY_EN
    logic [3:0] w_freeDigit;
    logic [6:0] w_freeSeg;
    logic [6:0] r_hexFree;

    assign w_freeDigit = 4'(CAP_VAL - r_occupancy);

    seg7_decoder u_seg7_decoder (
        .i_digit (w_freeDigit),
        .o_seg   (w_freeSeg)
    );

    // Display register lags the occupancy counter by one cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hexFree <= '0;
        end else begin
            r_hexFree <= w_freeSeg;
        end
    end

    assign hex_free = r_hexFree;
`endif

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Scoreboard bench for parking_gate_arbiter. Stimulus pushes the expected
// output snapshot and the cycle it must appear in; the monitor pops and
// compares whenever the DUT's output vector changes.
module tb_parking_gate_arbiter;

    localparam int CAPACITY    = 8;
    localparam int CW          = 4;
    localparam int TIMEOUT_CYC = 64;
    localparam int CLOSE_CYC   = 4;

    logic          clk        = 1'b0;
    logic          reset      = 1'b1;
    logic          req_entry  = 1'b0;
    logic          req_exit   = 1'b0;
    logic          auth_ok    = 1'b0;
    logic          gate_clear = 1'b0;
    logic          grant_entry;
    logic          grant_exit;
    logic          gate_open;
    logic          full;
    logic [CW-1:0] occupancy;
    logic          timeout_err;
`ifdef OCCUPANCY_DISPLAY_EN
    logic [6:0]    hex_free;
`endif

    parking_gate_arbiter #(
        .CAPACITY    (CAPACITY),
        .CW          (CW),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .CLOSE_CYC   (CLOSE_CYC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_entry   (req_entry),
        .req_exit    (req_exit),
        .auth_ok     (auth_ok),
        .gate_clear  (gate_clear),
        .grant_entry (grant_entry),
        .grant_exit  (grant_exit),
        .gate_open   (gate_open),
        .full        (full),
        .occupancy   (occupancy),
        .timeout_err (timeout_err)
`ifdef OCCUPANCY_DISPLAY_EN
        ,
        .hex_free    (hex_free)
`endif
    );

    always #5 clk = ~clk;

    // Free-running cycle count; at the negedge after posedge k it reads k
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cycle;
        logic [8:0] outs;
    } expect_t;

    expect_t    expQ[$];
    expect_t    popped;
    int         vectorsApplied = 0;
    int         miscompares    = 0;
    logic [8:0] lastSnap       = 9'h1FF;
    logic [8:0] curSnap;
    logic [3:0] expOcc         = 4'd0;
    int         t;

    assign curSnap = {grant_entry, grant_exit, gate_open, full, timeout_err, occupancy};

    // Expected snapshot {grant_entry, grant_exit, gate_open, full, timeout_err, occupancy}
    function automatic logic [8:0] mk(input bit ge, input bit gx, input bit go,
                                      input bit to, input logic [3:0] occ);
        return {ge, gx, go, (occ == 4'(CAPACITY)), to, occ};
    endfunction

    task automatic expectAt(input int c, input logic [8:0] v);
        expect_t e;
        e.cycle = c;
        e.outs  = v;
        expQ.push_back(e);
    endtask

    task automatic waitUntil(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [15:0] got, input logic [15:0] want);
        vectorsApplied++;
        if (got !== want) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, required %h", name, got, want);
        end
    endtask

    // Monitor: every change of the output vector must match the next expectation
    always @(negedge clk) begin
        if (curSnap !== lastSnap) begin
            vectorsApplied++;
            if (expQ.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL unexpected_change at cycle %0d: got %b, required no change",
                         cyc, curSnap);
            end else begin
                popped = expQ.pop_front();
                if (popped.cycle != cyc || popped.outs !== curSnap) begin
                    miscompares++;
                    $display("[TB] FAIL output_event: got %b at cycle %0d, required %b at cycle %0d",
                             curSnap, cyc, popped.outs, popped.cycle);
                end
            end
            lastSnap = curSnap;
        end
    end

    // One full lane service starting from IDLE at the current negedge:
    // grant, (entry: auth after authWait), OPEN for openWait cycles, CLOSE, IDLE.
    // Stray gate_clear in WAIT_AUTH and stray auth_ok in OPEN must be ignored.
    task automatic applyStimulus(input bit isExit, input int authWait, input int openWait,
                                 input bit dropReqs);
        int         t0;
        int         cOpen;
        int         cClose;
        logic [3:0] occNext;
        t0      = cyc;
        cOpen   = isExit ? t0 + 1 : t0 + authWait + 1;
        cClose  = cOpen + openWait;
        occNext = isExit ? expOcc - 4'd1 : expOcc + 4'd1;
        if (!isExit) begin
            expectAt(t0 + 1, mk(1, 0, 0, 0, expOcc));
            expectAt(cOpen,  mk(1, 0, 1, 0, expOcc));
            expectAt(cClose, mk(1, 0, 0, 0, occNext));
        end else begin
            expectAt(cOpen,  mk(0, 1, 1, 0, expOcc));
            expectAt(cClose, mk(0, 1, 0, 0, occNext));
        end
        expectAt(cClose + CLOSE_CYC, mk(0, 0, 0, 0, occNext));

        waitUntil(t0 + 1);
        if (dropReqs) begin
            req_entry = 1'b0;
            req_exit  = 1'b0;
        end
        if (!isExit) begin
            gate_clear = 1'b1;
            waitUntil(t0 + 2);
            gate_clear = 1'b0;
            waitUntil(t0 + authWait);
            auth_ok = 1'b1;
            waitUntil(cOpen);
            auth_ok = 1'b0;
        end
        waitUntil(cOpen + 1);
        auth_ok = 1'b1;
        waitUntil(cOpen + 2);
        auth_ok = 1'b0;
        waitUntil(cClose - 1);
        gate_clear = 1'b1;
        waitUntil(cClose);
        gate_clear = 1'b0;
        waitUntil(cClose + CLOSE_CYC);
        expOcc = occNext;
    endtask

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no end of stimulus, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenario sequence
    initial begin
        expectAt(1, mk(0, 0, 0, 0, 4'd0));
        waitUntil(2);
        reset = 1'b0;

        // Basic entry: auth in cycle 5, clear in cycle 10, request dropped mid-sequence
        req_entry = 1'b1;
        applyStimulus(0, 5, 5, 1);

        // Two more entries to reach occupancy 3
        req_entry = 1'b1;
        applyStimulus(0, 5, 3, 0);
        applyStimulus(0, 5, 3, 1);
`ifdef OCCUPANCY_DISPLAY_EN
        checkOutput("hex_free_digit5", 16'(hex_free), 16'(7'b0010010));
`endif

        // Contention: entry first, then exit, then entry again
        req_entry = 1'b1;
        req_exit  = 1'b1;
        applyStimulus(0, 5, 3, 0);
        applyStimulus(1, 0, 3, 0);
        applyStimulus(0, 5, 3, 1);

        // Entry with no auth: timeout pulse, back to IDLE, count unchanged
        t = cyc;
        req_entry = 1'b1;
        expectAt(t + 1,               mk(1, 0, 0, 0, expOcc));
        expectAt(t + TIMEOUT_CYC + 1, mk(0, 0, 0, 1, expOcc));
        expectAt(t + TIMEOUT_CYC + 2, mk(0, 0, 0, 0, expOcc));
        waitUntil(t + 1);
        req_entry = 1'b0;
        waitUntil(t + TIMEOUT_CYC + 2);

        // auth_ok on the timeout cycle wins
        req_entry = 1'b1;
        applyStimulus(0, TIMEOUT_CYC, 3, 1);

        // Fill to capacity
        req_entry = 1'b1;
        applyStimulus(0, 5, 3, 0);
        applyStimulus(0, 5, 3, 0);
        applyStimulus(0, 5, 3, 1);

        // Full: entry request is not granted
        req_entry = 1'b1;
        waitUntil(cyc + 10);
        checkOutput("full_blocks_entry", 16'({grant_entry, grant_exit, full}), 16'b001);
        req_entry = 1'b0;

        // Exit from full drops the full flag
        req_exit = 1'b1;
        applyStimulus(1, 0, 4, 1);

        // Exit OPEN with no gate_clear: timeout into CLOSE, count unchanged
        t = cyc;
        req_exit = 1'b1;
        expectAt(t + 1,                           mk(0, 1, 1, 0, expOcc));
        expectAt(t + TIMEOUT_CYC + 1,             mk(0, 1, 0, 1, expOcc));
        expectAt(t + TIMEOUT_CYC + 2,             mk(0, 1, 0, 0, expOcc));
        expectAt(t + TIMEOUT_CYC + 1 + CLOSE_CYC, mk(0, 0, 0, 0, expOcc));
        waitUntil(t + 1);
        req_exit = 1'b0;
        waitUntil(t + TIMEOUT_CYC + 1 + CLOSE_CYC);

        // Reset asserted in OPEN clears everything without waiting for a clock
        t = cyc;
        req_exit = 1'b1;
        expectAt(t + 1, mk(0, 1, 1, 0, expOcc));
        expectAt(t + 4, mk(0, 0, 0, 0, 4'd0));
        waitUntil(t + 3);
        #2 reset = 1'b1;
        #1 checkOutput("async_reset", 16'({grant_entry, grant_exit, gate_open, occupancy}), 16'd0);
        req_exit = 1'b0;
        expOcc   = 4'd0;
        waitUntil(t + 5);
        reset = 1'b0;

        // Empty: exit request is not granted; stray pulses in IDLE ignored
        t = cyc;
        req_exit = 1'b1;
        waitUntil(t + 3);
        auth_ok    = 1'b1;
        gate_clear = 1'b1;
        waitUntil(t + 4);
        auth_ok    = 1'b0;
        gate_clear = 1'b0;
        waitUntil(t + 10);
        checkOutput("empty_blocks_exit", 16'({grant_exit, gate_open, occupancy}), 16'd0);
        req_exit = 1'b0;

        // Normal entry still works after reset
        req_entry = 1'b1;
        applyStimulus(0, 5, 3, 1);

        waitUntil(cyc + 5);
        checkOutput("scoreboard_drained", 16'(expQ.size()), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule
